uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 130 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// uart_tx_arbiter : round-robin arbiter feeding one UART serializer word-wise.
// Optional tx_done watchdog compiled in with macro UART_TX_ARB_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_tx_arbiter #(
  parameter int N_REQ          = 4,
  parameter int DATA_BITS      = 16,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*DATA_BITS-1:0] req_data,
  output logic [N_REQ-1:0]           ack,
  output logic [DATA_BITS-1:0]       tx_din,
  output logic                       send_en,
  input  logic                       tx_done,
  output logic                       busy,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic [15:0]                frame_cnt,
  output logic                       timeout_err
);

  localparam int IDW = $clog2(N_REQ);
  localparam int GCW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   win_id;
  logic [IDW-1:0]   idx;
  logic             any_req;
  logic             expire;
  logic             gap_last;
  logic [GCW-1:0]   gap_cnt;

  // Scan from the farthest offset down so the last hit is the one nearest ptr.
  always_comb begin
    any_req = 1'b0;
    win_id  = '0;
    idx     = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = IDW'((int'(ptr) + k) % N_REQ);
      if (req[idx]) begin
        any_req = 1'b1;
        win_id  = idx;
      end
    end
  end

  assign gap_last = (gap_cnt == GCW'(GAP_CYCLES - 1));

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WDW-1:0] wd_cnt;

  // A tx_done arriving on the expiry cycle takes precedence over the timeout.
  assign expire = (state == WAIT) && !tx_done && (wd_cnt == WDW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= expire;
      if (state != WAIT) wd_cnt <= '0;
      else               wd_cnt <= wd_cnt + 1'b1;
    end
  end
`else
  assign expire      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    send_en   = 1'b0;
    ack       = '0;
    busy      = (state != IDLE);
    unique case (state)
      IDLE: if (any_req) state_nxt = LOAD;
      LOAD: begin
        send_en       = 1'b1;
        ack[grant_id] = 1'b1;
        state_nxt     = WAIT;
      end
      WAIT: if (tx_done || expire) state_nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
      GAP:  if (gap_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr       <= '0;
      tx_din    <= '0;
      grant_id  <= '0;
      frame_cnt <= '0;
      gap_cnt   <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        tx_din   <= req_data[win_id*DATA_BITS +: DATA_BITS];
        grant_id <= win_id;
        ptr      <= (win_id == IDW'(N_REQ - 1)) ? '0 : win_id + 1'b1;
      end
      if (state == WAIT && tx_done) frame_cnt <= frame_cnt + 16'd1;
      if (state == GAP) gap_cnt <= gap_cnt + 1'b1;
      else              gap_cnt <= '0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (default parameters).
`default_nettype none

module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [63:0] req_data;
  logic [3:0]  ack;
  logic [15:0] tx_din;
  logic        send_en;
  logic        tx_done;
  logic        busy;
  logic [1:0]  grant_id;
  logic [15:0] frame_cnt;
  logic        timeout_err;

  int total = 0;
  int bad   = 0;

  uart_tx_arbiter #(
    .N_REQ(4), .DATA_BITS(16), .GAP_CYCLES(2), .TIMEOUT_CYCLES(64)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .ack(ack),
    .tx_din(tx_din), .send_en(send_en), .tx_done(tx_done), .busy(busy),
    .grant_id(grant_id), .frame_cnt(frame_cnt), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; waits (bounded) for the LOAD cycle and checks the grant.
  task automatic wait_grant(input string tag, input logic [3:0] exp_ack,
                            input logic [1:0] exp_id, input logic [15:0] exp_din);
    int n = 0;
    while (send_en !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_send_en"}, 32'(send_en), 32'd1);
    chk({tag, "_ack"}, 32'(ack), 32'(exp_ack));
    chk({tag, "_grant_id"}, 32'(grant_id), 32'(exp_id));
    chk({tag, "_tx_din"}, 32'(tx_din), 32'(exp_din));
  endtask

  // Called at the LOAD negedge; returns a tx_done in WAIT and waits for IDLE.
  task automatic finish_frame(input string tag);
    int n = 0;
    @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    while (busy !== 1'b0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    req      = 4'b0000;
    tx_done  = 1'b0;
    req_data = {16'hC0D3, 16'hC0D2, 16'hC0D1, 16'hA5C3};
    repeat (2) @(negedge clk);

    // Reset values
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_send_en", 32'(send_en), 32'd0);
    chk("rst_tx_din", 32'(tx_din), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);

    // Single requester 0, tx_done 20 cycles after send_en
    rst_n = 1'b1;
    req   = 4'b0001;
    @(negedge clk);
    chk("t1_send_en", 32'(send_en), 32'd1);
    chk("t1_ack", 32'(ack), 32'h1);
    chk("t1_tx_din", 32'(tx_din), 32'hA5C3);
    chk("t1_busy", 32'(busy), 32'd1);
    req = 4'b0000;
    @(negedge clk);
    chk("t1_send_en_pulse", 32'(send_en), 32'd0);
    chk("t1_ack_pulse", 32'(ack), 32'd0);
    repeat (19) @(negedge clk);
    chk("t1_wait_busy", 32'(busy), 32'd1);
    chk("t1_hold_tx_din", 32'(tx_din), 32'hA5C3);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    chk("t1_frame_cnt", 32'(frame_cnt), 32'd1);
    chk("t1_gap1_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("t1_gap2_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("t1_idle_busy", 32'(busy), 32'd0);
    chk("t1_timeout_err", 32'(timeout_err), 32'd0);

    // tx_done outside WAIT is ignored
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    chk("stray_done_cnt", 32'(frame_cnt), 32'd1);
    chk("stray_done_busy", 32'(busy), 32'd0);

    // Fresh reset, all four requesting, each dropped after its ack
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req_data[15:0] = 16'hC0D0;
    req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      wait_grant($sformatf("rr%0d", i), 4'(1 << i), 2'(i), 16'hC0D0 + 16'(i));
      req[i] = 1'b0;
      finish_frame($sformatf("rr%0d", i));
    end
    req = 4'b1111;
    wait_grant("rr_wrap", 4'b0001, 2'd0, 16'hC0D0);
    req = 4'b0000;
    finish_frame("rr_wrap");
    chk("rr_frame_cnt", 32'(frame_cnt), 32'd5);

    // Grant 2 moves ptr to 3; then 0 beats 2
    req = 4'b0100;
    wait_grant("p2", 4'b0100, 2'd2, 16'hC0D2);
    req = 4'b0000;
    finish_frame("p2");
    req = 4'b0101;
    wait_grant("p3wrap", 4'b0001, 2'd0, 16'hC0D0);
    req = 4'b0000;
    finish_frame("p3wrap");
    chk("p_frame_cnt", 32'(frame_cnt), 32'd7);

    // tx_done never returned
    req = 4'b0010;
    wait_grant("to", 4'b0010, 2'd1, 16'hC0D1);
    req = 4'b0000;
    @(negedge clk);
`ifdef UART_TX_ARB_TIMEOUT_EN
    repeat (63) @(negedge clk);
    chk("to_before", 32'(timeout_err), 32'd0);
    chk("to_before_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("to_pulse", 32'(timeout_err), 32'd1);
    chk("to_frame_cnt", 32'(frame_cnt), 32'd7);
    @(negedge clk);
    chk("to_pulse_end", 32'(timeout_err), 32'd0);
`else
    repeat (70) @(negedge clk);
    chk("nto_err", 32'(timeout_err), 32'd0);
    chk("nto_busy", 32'(busy), 32'd1);
    chk("nto_frame_cnt", 32'(frame_cnt), 32'd7);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    chk("nto_done_cnt", 32'(frame_cnt), 32'd8);
`endif
    begin
      int n = 0;
      while (busy !== 1'b0 && n < 10) begin
        @(negedge clk);
        n++;
      end
      chk("to_idle", 32'(busy), 32'd0);
    end
    req = 4'b1000;
    wait_grant("to_next", 4'b1000, 2'd3, 16'hC0D3);
    req = 4'b0000;
    finish_frame("to_next");
`ifdef UART_TX_ARB_TIMEOUT_EN
    chk("to_next_cnt", 32'(frame_cnt), 32'd8);
`else
    chk("to_next_cnt", 32'(frame_cnt), 32'd9);
`endif

    // Reset during WAIT with ptr at 2
    req = 4'b0010;
    wait_grant("mr", 4'b0010, 2'd1, 16'hC0D1);
    req = 4'b0000;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_ack", 32'(ack), 32'd0);
    chk("mr_send_en", 32'(send_en), 32'd0);
    chk("mr_tx_din", 32'(tx_din), 32'd0);
    chk("mr_grant_id", 32'(grant_id), 32'd0);
    chk("mr_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("mr_timeout_err", 32'(timeout_err), 32'd0);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    chk("mr_late_done_cnt", 32'(frame_cnt), 32'd0);
    chk("mr_late_done_busy", 32'(busy), 32'd0);
    req = 4'b0101;
    wait_grant("mr_ptr0", 4'b0001, 2'd0, 16'hC0D0);
    req = 4'b0000;
    finish_frame("mr_ptr0");
    chk("mr_cnt_after", 32'(frame_cnt), 32'd1);

    // frame_cnt wrap from 0xFFFF
    force dut.frame_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt;
    chk("wrap_preload", 32'(frame_cnt), 32'hFFFF);
    req = 4'b0100;
    wait_grant("wrap", 4'b0100, 2'd2, 16'hC0D2);
    req = 4'b0000;
    finish_frame("wrap");
    chk("wrap_cnt", 32'(frame_cnt), 32'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
